// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the M-stage memory access controller: FSM encoding,
// access-size codes and the store-lane replication helper.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Size 2'b11 is illegal and falls through to the word case.
  function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                              input logic [1:0]  size);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wdata[7:0]}};
      SIZE_HALF: lanes = {2{wdata[15:0]}};
      default:   lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load alignment: picks the addressed byte/half lane from the raw
// bus word and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_BYTE: result = {{24{sign & w_byte[7]}}, w_byte};
      SIZE_HALF: result = {{16{sign & w_half[15]}}, w_half};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: turns a load/store into one SRAM-like
// request/response handshake and stalls the pipeline until it completes.
//
// state  | meaning
// IDLE   | no access in flight; captures a new unflushed load/store
// REQ    | data_req high, waiting for data_addr_ok
// WAIT   | request accepted, waiting for data_data_ok
// DONE   | one-cycle release of the stall after a non-cancelled access
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  mem_size_m,
  input  logic        mem_sign_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        flush_m,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_m,
  output logic [31:0] read_data_m
);

  state_t      r_state;
  logic        r_req;
  logic        r_wr;
  logic        r_sign;
  logic        r_cancel;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata_m;

  logic        w_start;
  logic [31:0] w_load_data;

  assign w_start = (mem_read_m | mem_write_m) & ~flush_m;

  mem_load_align u_load_align (
    .rdata  (data_rdata),
    .addr   (r_addr[1:0]),
    .size   (r_size),
    .sign   (r_sign),
    .result (w_load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_sign    <= 1'b0;
      r_cancel  <= 1'b0;
      r_size    <= 2'b00;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata_m <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_start) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_wr    <= mem_write_m;
            r_size  <= mem_size_m;
            r_sign  <= mem_sign_m;
            r_addr  <= addr_m;
            r_wdata <= store_lanes(wdata_m, mem_size_m);
          end
        end
        S_REQ: begin
          // A flush here cannot withdraw the request; it only marks it for draining.
          if (flush_m) r_cancel <= 1'b1;
          if (data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_m) r_cancel <= 1'b1;
          if (data_data_ok) begin
            if (r_cancel || flush_m) begin
              r_cancel <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              if (!r_wr) r_rdata_m <= w_load_data;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The IDLE term must be combinational so the requesting instruction is held
  // in M on the very cycle it is captured.
  assign stall_m = (r_state == S_REQ) || (r_state == S_WAIT) ||
                   ((r_state == S_IDLE) && w_start);

  assign data_req    = r_req;
  assign data_wr     = r_wr;
  assign data_size   = r_size;
  assign data_addr   = r_addr;
  assign data_wdata  = r_wdata;
  assign read_data_m = r_rdata_m;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// loads/stores against a lane-arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clock;
  logic        reset;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [1:0]  mem_size_m;
  logic        mem_sign_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        flush_m;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stall_m;
  logic [31:0] read_data_m;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd  = 32'd0;

  mem_access_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .mem_size_m   (mem_size_m),
    .mem_sign_m   (mem_sign_m),
    .addr_m       (addr_m),
    .wdata_m      (wdata_m),
    .flush_m      (flush_m),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .stall_m      (stall_m),
    .read_data_m  (read_data_m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic drive_idle();
    mem_read_m   = 1'b0;
    mem_write_m  = 1'b0;
    mem_size_m   = 2'd0;
    mem_sign_m   = 1'b0;
    addr_m       = 32'd0;
    wdata_m      = 32'd0;
    flush_m      = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
  endtask

  // flush_at: -1 none, 0 first REQ cycle, 1 first WAIT cycle
  task automatic run_txn(input logic is_wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int addr_dly, input int data_dly, input int flush_at,
                         input logic [31:0] rd);
    logic cancelled;
    cancelled   = (flush_at >= 0);
    mem_read_m  = !is_wr;
    mem_write_m = is_wr;
    mem_size_m  = sz;
    mem_sign_m  = sg;
    addr_m      = a;
    wdata_m     = wd;
    #1;
    check("stall_capture", 32'(stall_m), 32'd1);
    @(posedge clock); #1;
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    addr_m      = $urandom;
    wdata_m     = $urandom;
    mem_size_m  = 2'($urandom_range(0, 3));
    for (int i = 0; i <= addr_dly; i++) begin
      flush_m      = (flush_at == 0 && i == 0);
      data_addr_ok = (i == addr_dly);
      data_data_ok = (i != addr_dly) && ($urandom_range(0, 1) == 1);
      data_rdata   = $urandom;
      #1;
      check("req_high",  32'(data_req), 32'd1);
      check("req_stall", 32'(stall_m), 32'd1);
      check("req_addr",  data_addr, a);
      check("req_wr",    32'(data_wr), 32'(is_wr));
      check("req_size",  32'(data_size), 32'(sz));
      if (is_wr) check("req_wdata", data_wdata, ref_store(wd, sz));
      @(posedge clock); #1;
    end
    flush_m      = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    for (int j = 0; j <= data_dly; j++) begin
      flush_m      = (flush_at == 1 && j == 0);
      data_data_ok = (j == data_dly);
      data_rdata   = (j == data_dly) ? rd : $urandom;
      #1;
      check("wait_req_low", 32'(data_req), 32'd0);
      check("wait_stall",   32'(stall_m), 32'd1);
      @(posedge clock); #1;
    end
    flush_m      = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    if (!cancelled && !is_wr) exp_rd = ref_load(rd, a[1:0], sz, sg);
    if (!cancelled) begin
      flush_m = 1'($urandom_range(0, 1));
      #1;
      check("done_stall", 32'(stall_m), 32'd0);
      check("done_rdata", read_data_m, exp_rd);
      @(posedge clock); #1;
      flush_m = 1'b0;
    end
    #1;
    check("idle_stall", 32'(stall_m), 32'd0);
    check("idle_req",   32'(data_req), 32'd0);
    check("idle_rdata", read_data_m, exp_rd);
  endtask

  initial begin
    logic        t_wr;
    logic        t_sg;
    logic [1:0]  t_sz;
    int          t_fl;
    int unsigned t_r;

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req",   32'(data_req), 32'd0);
    check("rst_wr",    32'(data_wr), 32'd0);
    check("rst_size",  32'(data_size), 32'd0);
    check("rst_addr",  data_addr, 32'd0);
    check("rst_wdata", data_wdata, 32'd0);
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_rdata", read_data_m, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // LB sign-extended, LHU, SW, SB with slow accept, cancelled LW
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 0, 0, -1, 32'h80FF_1234);
    check("lb_value", read_data_m, 32'hFFFF_FF80);
    run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'd0, 0, 0, -1, 32'hBEEF_0000);
    check("lhu_value", read_data_m, 32'h0000_BEEF);
    run_txn(1'b1, 2'd2, 1'b0, 32'h0000_2000, 32'h1122_3344, 0, 0, -1, 32'd0);
    run_txn(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00A5, 4, 1, -1, 32'd0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0, 0, 2, 1, 32'hDEAD_BEEF);
    check("flush_keeps", read_data_m, 32'h0000_BEEF);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3004, 32'd0, 1, 0, -1, 32'h0BAD_F00D);

    // a flushed request in IDLE is never captured
    mem_read_m = 1'b1;
    flush_m    = 1'b1;
    #1;
    check("idle_flush_stall", 32'(stall_m), 32'd0);
    @(posedge clock); #1;
    drive_idle();
    #1;
    check("idle_flush_req", 32'(data_req), 32'd0);
    check("idle_flush_stall2", 32'(stall_m), 32'd0);

    for (int k = 0; k < 60; k++) begin
      t_wr = 1'($urandom_range(0, 1));
      t_sz = 2'($urandom_range(0, 3));
      t_sg = 1'($urandom_range(0, 1));
      t_r  = $urandom_range(0, 7);
      t_fl = (t_r == 0) ? 0 : (t_r == 1) ? 1 : -1;
      run_txn(t_wr, t_sz, t_sg, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), t_fl, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
        check("gap_stall", 32'(stall_m), 32'd0);
      end
    end

    // reset while waiting for the response, then a stray response
    @(posedge clock); #1;
    mem_read_m = 1'b1;
    mem_size_m = 2'd2;
    addr_m     = 32'h0000_4000;
    @(posedge clock); #1;
    drive_idle();
    data_addr_ok = 1'b1;
    @(posedge clock); #1;
    data_addr_ok = 1'b0;
    check("pre_rst_wait_stall", 32'(stall_m), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset  = 1'b0;
    exp_rd = 32'd0;
    #1;
    check("mid_rst_req",   32'(data_req), 32'd0);
    check("mid_rst_stall", 32'(stall_m), 32'd0);
    check("mid_rst_rdata", read_data_m, exp_rd);
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    @(posedge clock); #1;
    data_data_ok = 1'b0;
    #1;
    check("stray_rdata", read_data_m, exp_rd);
    check("stray_stall", 32'(stall_m), 32'd0);
    check("stray_req",   32'(data_req), 32'd0);
    @(posedge clock); #1;
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_5002, 32'd0, 2, 1, -1, 32'h0077_0000);
    check("post_rst_lbu", read_data_m, 32'h0000_0077);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
